fc_seq_ctrl: RTL

FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

---
 rtl/fc_seq_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fc_seq_ctrl.sv
// rtl/fc_seq_ctrl.sv - two-layer FC inference sequencer with shared memory write port
// Optional feature: define FC_SEQ_WCNT_CHECK_EN to flag err when a layer ends
// with a write count different from MID_CELL (layer 1) or BCK_CELL (layer 2).
module fc_seq_ctrl #(
  parameter int          MID_CELL = 20,
  parameter int          BCK_CELL = 10,
  parameter logic [15:0] L2_BASE  = 16'd32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        l1_en,
  output logic        l2_en,
  input  logic        l1_we,
  input  logic        l2_we,
  input  logic [15:0] l1_addr,
  input  logic [15:0] l2_addr,
  input  logic [15:0] l1_data,
  input  logic [15:0] l2_data,
  input  logic        l1_end,
  input  logic        l2_end,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RUN1, RUN2, DONE} state_t;

`ifdef FC_SEQ_WCNT_CHECK_EN
  localparam bit WCNT_CHECK = 1'b1;
`else
  localparam bit WCNT_CHECK = 1'b0;
`endif

  localparam logic [15:0] MID_TGT = 16'(MID_CELL);
  localparam logic [15:0] BCK_TGT = 16'(BCK_CELL);

  state_t      state;
  logic [15:0] wcnt;

  logic        fwd1;
  logic        fwd2;
  logic        fwd;
  logic        stray;
  logic [15:0] l2_mapped;
  logic [15:0] wcnt_inc;
  logic        cnt_mismatch;
  logic        cnt_bad;

  // Only the layer owning the current phase reaches memory; the other one is an error.
  assign fwd1      = (state == RUN1) && l1_we;
  assign fwd2      = (state == RUN2) && l2_we;
  assign fwd       = fwd1 || fwd2;
  assign stray     = ((state == RUN1) && l2_we) || ((state == RUN2) && l1_we);
  assign l2_mapped = l2_addr + L2_BASE;

  // Count including a write landing in the same cycle as the end pulse, saturating.
  assign wcnt_inc  = (fwd && (wcnt != 16'hFFFF)) ? wcnt + 16'd1 : wcnt;

  assign cnt_mismatch = ((state == RUN1) && l1_end && (wcnt_inc != MID_TGT)) ||
                        ((state == RUN2) && l2_end && (wcnt_inc != BCK_TGT));
  assign cnt_bad      = WCNT_CHECK && cnt_mismatch;

  // Sequencer FSM with registered enables, status and memory write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wcnt     <= 16'd0;
      l1_en    <= 1'b0;
      l2_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 16'd0;
      mem_data <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (abort) begin
        // Abort wins over everything, including a write in flight this cycle.
        state <= IDLE;
        l1_en <= 1'b0;
        l2_en <= 1'b0;
        busy  <= 1'b0;
      end else begin
        if (fwd) begin
          mem_we   <= 1'b1;
          mem_addr <= fwd2 ? l2_mapped : l1_addr;
          mem_data <= fwd2 ? l2_data : l1_data;
        end
        case (state)
          IDLE: begin
            if (start) begin
              state <= RUN1;
              l1_en <= 1'b1;
              busy  <= 1'b1;
              err   <= 1'b0;
              wcnt  <= 16'd0;
            end
          end
          RUN1: begin
            if (stray || cnt_bad) err <= 1'b1;
            if (l1_end) begin
              state <= RUN2;
              l1_en <= 1'b0;
              l2_en <= 1'b1;
              wcnt  <= 16'd0;
            end else begin
              wcnt <= wcnt_inc;
            end
          end
          RUN2: begin
            if (stray || cnt_bad) err <= 1'b1;
            if (l2_end) begin
              state <= DONE;
              l2_en <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              wcnt  <= 16'd0;
            end else begin
              wcnt <= wcnt_inc;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
